// File: rtl/tron_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tron_pkg: shared screen geometry, coordinate types and plotter    |
// | state encoding.                          Revision: 1.0            |
// +------------------------------------------------------------------+
package tron_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int FRAME_ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        CLEAR   = 3'd4
    } plot_state_t;

    typedef logic [9:0] x_t;
    typedef logic [8:0] y_t;

endpackage
`default_nettype wire

// File: rtl/trail_plotter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trail_plotter: read-modify-write pixel setter with collision/wall |
// | reporting and full-frame wipe.           Revision: 1.0            |
// +------------------------------------------------------------------+
module trail_plotter
    import tron_pkg::*;
#(
    parameter int COLS   = SCREEN_W,
    parameter int ROWS   = SCREEN_H,
    parameter int ADDR_W = FRAME_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [9:0]        i_req_x,
    input  logic [8:0]        i_req_y,
    input  logic              i_req_write,
    output logic              o_done,
    output logic              o_collision,
    output logic              o_out_of_bounds,
    input  logic              i_clear_start,
    output logic              o_clear_busy,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_ram_read_address,
    input  logic [ROWS-1:0]   i_ram_rdata,
    output logic [ADDR_W-1:0] o_ram_write_address,
    output logic [ROWS-1:0]   o_ram_wdata,
    output logic              o_ram_we
);

    localparam x_t                c_COLS_X    = x_t'(COLS);
    localparam y_t                c_ROWS_Y    = y_t'(ROWS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(COLS - 1);

    plot_state_t       r_state, w_state_nxt;
    x_t                r_x, w_x_nxt;
    y_t                r_y, w_y_nxt;
    logic              r_write, w_write_nxt;
    logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
    logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
    logic [ROWS-1:0]   r_wdata, w_wdata_nxt;
    logic              r_we, w_we_nxt;
    logic              r_done, w_done_nxt;
    logic              r_coll, w_coll_nxt;
    logic              r_oob, w_oob_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_cdone, w_cdone_nxt;
    logic              w_req_oob;

    assign w_req_oob   = (i_req_x >= c_COLS_X) || (i_req_y >= c_ROWS_Y);
    assign o_req_ready = (r_state == IDLE) && !i_clear_start;

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_write_nxt = r_write;
        w_raddr_nxt = r_raddr;
        w_waddr_nxt = r_waddr;
        w_wdata_nxt = r_wdata;
        w_we_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_coll_nxt  = r_coll;
        w_oob_nxt   = r_oob;
        w_busy_nxt  = r_busy;
        w_cdone_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                // A wipe request wins; any coincident plot request stays pending.
                if (i_clear_start) begin
                    w_state_nxt = CLEAR;
                    w_busy_nxt  = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = '0;
                    w_waddr_nxt = '0;
                end else if (i_req_valid) begin
                    w_x_nxt     = i_req_x;
                    w_y_nxt     = i_req_y;
                    w_write_nxt = i_req_write;
                    if (w_req_oob) begin
                        w_done_nxt = 1'b1;
                        w_oob_nxt  = 1'b1;
                        w_coll_nxt = 1'b1;
                    end else begin
                        w_raddr_nxt = ADDR_W'(i_req_x);
                        w_state_nxt = RD_ADDR;
                    end
                end
            end
            RD_ADDR: w_state_nxt = RD_DATA;
            RD_DATA: begin
                w_coll_nxt = i_ram_rdata[r_y];
                w_oob_nxt  = 1'b0;
                w_done_nxt = 1'b1;
                if (r_write) begin
                    w_waddr_nxt = ADDR_W'(r_x);
                    w_wdata_nxt = i_ram_rdata | (ROWS'(1) << r_y);
                    w_we_nxt    = 1'b1;
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WRITE: w_state_nxt = IDLE;
            CLEAR: begin
                // The write address doubles as the wipe counter.
                if (r_waddr == c_LAST_ADDR) begin
                    w_busy_nxt  = 1'b0;
                    w_cdone_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_waddr + ADDR_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_write <= 1'b0;
            r_raddr <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            r_coll  <= 1'b0;
            r_oob   <= 1'b0;
            r_busy  <= 1'b0;
            r_cdone <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_write <= w_write_nxt;
            r_raddr <= w_raddr_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_done  <= w_done_nxt;
            r_coll  <= w_coll_nxt;
            r_oob   <= w_oob_nxt;
            r_busy  <= w_busy_nxt;
            r_cdone <= w_cdone_nxt;
        end
    end

    assign o_done              = r_done;
    assign o_collision         = r_coll;
    assign o_out_of_bounds     = r_oob;
    assign o_clear_busy        = r_busy;
    assign o_clear_done        = r_cdone;
    assign o_ram_read_address  = r_raddr;
    assign o_ram_write_address = r_waddr;
    assign o_ram_wdata         = r_wdata;
    assign o_ram_we            = r_we;

endmodule
`default_nettype wire

// File: tb/tb_trail_plotter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_trail_plotter: directed bench with a 1-cycle-read frame RAM.   |
// |                                           Revision: 1.0           |
// +------------------------------------------------------------------+
module tb_trail_plotter;

    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int AW   = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [9:0]      req_x = '0;
    logic [8:0]      req_y = '0;
    logic            req_write = 1'b0;
    logic            done, collision, oob;
    logic            clear_start = 1'b0;
    logic            clear_busy, clear_done;
    logic [AW-1:0]   ram_raddr, ram_waddr;
    logic [ROWS-1:0] ram_rdata = '0;
    logic [ROWS-1:0] ram_wdata;
    logic            ram_we;

    logic [ROWS-1:0] mem [0:COLS-1];
    logic            fill = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int p_lat, p_we;
    logic p_coll, p_oob;
    logic [ROWS-1:0] exp_w;

    always #5 clk = ~clk;

    trail_plotter dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_req_valid         (req_valid),
        .o_req_ready         (req_ready),
        .i_req_x             (req_x),
        .i_req_y             (req_y),
        .i_req_write         (req_write),
        .o_done              (done),
        .o_collision         (collision),
        .o_out_of_bounds     (oob),
        .i_clear_start       (clear_start),
        .o_clear_busy        (clear_busy),
        .o_clear_done        (clear_done),
        .o_ram_read_address  (ram_raddr),
        .i_ram_rdata         (ram_rdata),
        .o_ram_write_address (ram_waddr),
        .o_ram_wdata         (ram_wdata),
        .o_ram_we            (ram_we)
    );

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < COLS; i++) mem[i] <= {15{32'hDEADBEEF}};
        end else if (ram_we && int'(ram_waddr) < COLS) begin
            mem[ram_waddr[9:0]] <= ram_wdata;
        end
        if (int'(ram_raddr) < COLS) ram_rdata <= mem[ram_raddr[9:0]];
        else                        ram_rdata <= '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [ROWS-1:0] obs, input logic [ROWS-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int nonzero_except(input int skip);
        int n = 0;
        for (int i = 0; i < COLS; i++)
            if (i != skip && mem[i] != '0) n++;
        return n;
    endfunction

    // Issues one request and returns latency (edges from accept to done), flags and ram_we count.
    task automatic plot(input logic [9:0] x, input logic [8:0] y, input logic w);
        int guard;
        p_we = 0;
        req_x = x; req_y = y; req_write = w; req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 1000) begin tick(); guard++; end
        chk1("ready_wait", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        p_lat = 1;
        guard = 0;
        while (!done && guard < 10) begin
            if (ram_we) p_we++;
            tick(); p_lat++; guard++;
        end
        p_coll = collision;
        p_oob  = oob;
        if (ram_we) p_we++;
        guard = 0;
        while (!req_ready && guard < 10) begin
            tick(); guard++;
            if (ram_we) p_we++;
        end
    endtask

    initial begin
        int guard, bad;

        // Reset with RAM preloaded with a non-zero pattern.
        rst = 1'b1;
        tick();
        fill = 1'b1;
        tick();
        fill = 1'b0;
        tick();
        chk1("rst_we", ram_we, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_coll", collision, 1'b0);
        chk1("rst_oob", oob, 1'b0);
        chk1("rst_busy", clear_busy, 1'b0);
        chk1("rst_cdone", clear_done, 1'b0);
        chkn("rst_raddr", int'(ram_raddr), 0);
        chkn("rst_waddr", int'(ram_waddr), 0);
        chkw("rst_wdata", ram_wdata, '0);
        chk1("rst_ready", req_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Full wipe.
        clear_start = 1'b1;
        #1;
        chk1("clr_ready_low", req_ready, 1'b0);
        tick();
        clear_start = 1'b0;
        bad = 0;
        for (int i = 0; i < COLS; i++) begin
            if (clear_busy !== 1'b1 || ram_we !== 1'b1 || int'(ram_waddr) != i
                || ram_wdata !== '0 || clear_done !== 1'b0) bad++;
            tick();
        end
        chkn("clr_sequence_bad_cycles", bad, 0);
        chk1("clr_done_pulse", clear_done, 1'b1);
        chk1("clr_busy_end", clear_busy, 1'b0);
        chk1("clr_we_end", ram_we, 1'b0);
        tick();
        chk1("clr_done_drop", clear_done, 1'b0);
        chk1("clr_we_after", ram_we, 1'b0);
        chkn("clr_nonzero_words", nonzero_except(-1), 0);

        // First plot on empty RAM.
        plot(10'd100, 9'd37, 1'b1);
        exp_w = '0; exp_w[37] = 1'b1;
        chkn("p1_latency", p_lat, 3);
        chk1("p1_coll", p_coll, 1'b0);
        chk1("p1_oob", p_oob, 1'b0);
        chkn("p1_we_count", p_we, 1);
        chkw("p1_word100", mem[100], exp_w);
        chkn("p1_other_words", nonzero_except(100), 0);

        // Same pixel back-to-back: collision, word unchanged, still written.
        plot(10'd100, 9'd37, 1'b1);
        chk1("p2_coll", p_coll, 1'b1);
        chkn("p2_we_count", p_we, 1);
        chkw("p2_word100", mem[100], exp_w);

        plot(10'd100, 9'd38, 1'b1);
        exp_w[38] = 1'b1;
        chk1("p3_coll", p_coll, 1'b0);
        chkw("p3_word100", mem[100], exp_w);

        // Walls.
        plot(10'd640, 9'd10, 1'b1);
        chkn("oobx_latency", p_lat, 1);
        chk1("oobx_flag", p_oob, 1'b1);
        chk1("oobx_coll", p_coll, 1'b1);
        chkn("oobx_we_count", p_we, 0);
        plot(10'd5, 9'd480, 1'b1);
        chkn("ooby_latency", p_lat, 1);
        chk1("ooby_flag", p_oob, 1'b1);
        chk1("ooby_coll", p_coll, 1'b1);
        chkn("ooby_we_count", p_we, 0);
        chkw("oob_word5", mem[5], '0);

        // Probe only.
        plot(10'd100, 9'd37, 1'b0);
        chkn("probe_latency", p_lat, 3);
        chk1("probe_coll", p_coll, 1'b1);
        chk1("probe_oob", p_oob, 1'b0);
        chkn("probe_we_count", p_we, 0);
        tick();
        chk1("probe_coll_hold", collision, 1'b1);
        chk1("probe_done_pulse", done, 1'b0);

        // Corner pixels.
        plot(10'd639, 9'd479, 1'b1);
        exp_w = '0; exp_w[479] = 1'b1;
        chk1("corner_coll", p_coll, 1'b0);
        chkw("corner_word639", mem[639], exp_w);
        plot(10'd0, 9'd0, 1'b1);
        exp_w = '0; exp_w[0] = 1'b1;
        chkw("corner_word0", mem[0], exp_w);

        // Clear and request in the same IDLE cycle: clear wins, request waits.
        req_x = 10'd7; req_y = 9'd7; req_write = 1'b1; req_valid = 1'b1;
        clear_start = 1'b1;
        #1;
        chk1("sim_ready_low", req_ready, 1'b0);
        tick();
        clear_start = 1'b0;
        chk1("sim_busy", clear_busy, 1'b1);
        bad = 0;
        guard = 0;
        while (!clear_done && guard < 700) begin
            if (req_ready) bad++;
            tick(); guard++;
        end
        chkn("sim_clear_cycles", guard, COLS);
        chkn("sim_ready_during_clear", bad, 0);
        plot(10'd7, 9'd7, 1'b1);
        exp_w = '0; exp_w[7] = 1'b1;
        chk1("sim_plot_coll", p_coll, 1'b0);
        chkw("sim_word7", mem[7], exp_w);
        chkw("sim_word100_wiped", mem[100], '0);

        // Asynchronous reset in the middle of a wipe.
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        guard = 0;
        while (int'(ram_waddr) != 300 && guard < 1000) begin tick(); guard++; end
        chkn("rc_reach_300", int'(ram_waddr), 300);
        chk1("rc_we_before", ram_we, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("rc_we_async", ram_we, 1'b0);
        chk1("rc_busy_async", clear_busy, 1'b0);
        #1 rst = 1'b0;
        chk1("rc_ready_release", req_ready, 1'b1);
        tick();
        chk1("rc_ready_next", req_ready, 1'b1);
        chk1("rc_we_next", ram_we, 1'b0);
        chk1("rc_busy_next", clear_busy, 1'b0);

        // Asynchronous reset while in WRITE.
        req_x = 10'd200; req_y = 9'd1; req_write = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk1("rw_we_in_write", ram_we, 1'b1);
        chk1("rw_done", done, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("rw_we_async", ram_we, 1'b0);
        chk1("rw_done_async", done, 1'b0);
        #1 rst = 1'b0;
        chk1("rw_ready_release", req_ready, 1'b1);
        tick();
        chk1("rw_ready_next", req_ready, 1'b1);
        chkw("rw_word200_unwritten", mem[200], '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
